// File: rtl/filter_sweep_ctrl_pkg.sv
// ============================================================================
// Module  : opo_package
// Brief   : Shared state encoding and defaults for the filter sweep controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package opo_package;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    REPORT  = 3'd4
  } sweep_state_t;

  localparam int C_FLUSH_CYCLES = 100;

endpackage

`default_nettype wire

// File: rtl/filter_sweep_ctrl_minmax.sv
// ============================================================================
// Module  : sweep_minmax
// Brief   : Signed running min/max; outputs already include the current sample.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sweep_minmax #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [WORD_WIDTH-1:0] sample,
  output logic [WORD_WIDTH-1:0] min,
  output logic [WORD_WIDTH-1:0] max
);

  localparam logic signed [WORD_WIDTH-1:0] C_POS_MAX = {1'b0, {(WORD_WIDTH-1){1'b1}}};
  localparam logic signed [WORD_WIDTH-1:0] C_NEG_MAX = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  logic signed [WORD_WIDTH-1:0] r_min, r_max;
  logic signed [WORD_WIDTH-1:0] w_smp, w_base_min, w_base_max, w_min, w_max;

  // clear restarts from the extremes in the same cycle, so a sample that
  // arrives together with clear is already counted
  always_comb begin
    w_smp      = $signed(sample);
    w_base_min = clear ? C_POS_MAX : r_min;
    w_base_max = clear ? C_NEG_MAX : r_max;
    w_min      = (valid && (w_smp < w_base_min)) ? w_smp : w_base_min;
    w_max      = (valid && (w_smp > w_base_max)) ? w_smp : w_base_max;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min <= C_POS_MAX;
      r_max <= C_NEG_MAX;
    end else begin
      r_min <= w_min;
      r_max <= w_max;
    end
  end

  assign min = w_min;
  assign max = w_max;

endmodule

`default_nettype wire

// File: rtl/filter_sweep_ctrl.sv
// ============================================================================
// Module  : filter_sweep_ctrl
// Brief   : Steps sine_gen period, flushes/settles the filter, reports min/max.
//           Define FILTER_SWEEP_PP_EN to add the res_pp peak-to-peak output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module filter_sweep_ctrl
  import opo_package::*;
#(
  parameter int WORD_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 32,
  parameter int FLUSH_CYCLES = C_FLUSH_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PERIOD_WIDTH-1:0] period_start,
  input  logic [PERIOD_WIDTH-1:0] period_step,
  input  logic [PERIOD_WIDTH-1:0] period_stop,
  input  logic [31:0]             settle_cycles,
  input  logic [31:0]             meas_cycles,
  output logic [PERIOD_WIDTH-1:0] gen_period,
  output logic                    dut_rst,
  input  logic [WORD_WIDTH-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [PERIOD_WIDTH-1:0] res_period,
  output logic [WORD_WIDTH-1:0]   res_max,
  output logic [WORD_WIDTH-1:0]   res_min,
`ifdef FILTER_SWEEP_PP_EN
  output logic [WORD_WIDTH:0]     res_pp,
`endif
  output logic                    busy,
  output logic                    done
);

  sweep_state_t r_state, w_state_nxt;

  logic [PERIOD_WIDTH-1:0] r_step, r_stop, r_gen_period, r_res_period;
  logic [31:0]             r_settle, r_meas, r_cnt;
  logic [WORD_WIDTH-1:0]   r_res_max, r_res_min, w_mm_min, w_mm_max;
  logic                    r_done;
  logic [PERIOD_WIDTH:0]   w_next_period;
  logic                    w_sweep_end, w_meas_last, w_xfer;

  assign w_next_period = {1'b0, r_gen_period} + {1'b0, r_step};
  assign w_sweep_end   = (r_step == '0) || w_next_period[PERIOD_WIDTH] ||
                         (w_next_period[PERIOD_WIDTH-1:0] > r_stop);
  // meas_cycles of zero still measures for one cycle
  assign w_meas_last   = ({1'b0, r_cnt} + 33'd1) >= {1'b0, r_meas};
  assign w_xfer        = (r_state == REPORT) && res_ready && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = FLUSH;
      FLUSH:   if (r_cnt == 32'(FLUSH_CYCLES - 1))
                 w_state_nxt = (r_settle == '0) ? MEASURE : SETTLE;
      SETTLE:  if (r_cnt == r_settle - 32'd1) w_state_nxt = MEASURE;
      MEASURE: if (w_meas_last) w_state_nxt = REPORT;
      REPORT:  if (res_ready) w_state_nxt = w_sweep_end ? IDLE : FLUSH;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  sweep_minmax #(.WORD_WIDTH(WORD_WIDTH)) u_minmax (
    .clk    (clk),
    .rst    (rst),
    .clear  ((r_state == MEASURE) && (r_cnt == '0)),
    .valid  ((r_state == MEASURE) && sample_valid),
    .sample (sample_in),
    .min    (w_mm_min),
    .max    (w_mm_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_step       <= '0;
      r_stop       <= '0;
      r_settle     <= '0;
      r_meas       <= '0;
      r_gen_period <= '0;
      r_res_period <= '0;
      r_res_max    <= '0;
      r_res_min    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_cnt  <= (w_state_nxt != r_state || r_state == IDLE) ? '0 : r_cnt + 32'd1;
      r_done <= w_xfer && w_sweep_end;
      if (r_state == IDLE && w_state_nxt == FLUSH) begin
        r_step       <= period_step;
        r_stop       <= period_stop;
        r_settle     <= settle_cycles;
        r_meas       <= meas_cycles;
        r_gen_period <= period_start;
      end
      if (w_xfer && !w_sweep_end) r_gen_period <= w_next_period[PERIOD_WIDTH-1:0];
      if (r_state == MEASURE && w_state_nxt == REPORT) begin
        r_res_period <= r_gen_period;
        r_res_max    <= w_mm_max;
        r_res_min    <= w_mm_min;
      end
    end
  end

`ifdef FILTER_SWEEP_PP_EN
  logic [WORD_WIDTH:0] r_res_pp;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_res_pp <= '0;
    else if (r_state == MEASURE && w_state_nxt == REPORT)
      r_res_pp <= {w_mm_max[WORD_WIDTH-1], w_mm_max} - {w_mm_min[WORD_WIDTH-1], w_mm_min};
  end
  assign res_pp = r_res_pp;
`endif

  assign gen_period = r_gen_period;
  assign dut_rst    = (r_state == SETTLE) || (r_state == MEASURE) || (r_state == REPORT);
  assign res_valid  = (r_state == REPORT);
  assign res_period = r_res_period;
  assign res_max    = r_res_max;
  assign res_min    = r_res_min;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_filter_sweep_ctrl.sv
// ============================================================================
// Module  : tb_filter_sweep_ctrl
// Brief   : Directed self-checking bench for filter_sweep_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_filter_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] period_start = '0, period_step = '0, period_stop = '0;
  logic [31:0] settle_cycles = '0, meas_cycles = '0;
  logic [31:0] gen_period;
  logic        dut_rst;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        res_valid, res_ready = 1'b0;
  logic [31:0] res_period;
  logic [15:0] res_max, res_min;
`ifdef FILTER_SWEEP_PP_EN
  logic [16:0] res_pp;
`endif
  logic        busy, done;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int ramp = -5;
  bit ramp_en = 1'b0;

  always #5 clk = ~clk;

  filter_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .period_start(period_start), .period_step(period_step), .period_stop(period_stop),
    .settle_cycles(settle_cycles), .meas_cycles(meas_cycles),
    .gen_period(gen_period), .dut_rst(dut_rst),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_period(res_period),
    .res_max(res_max), .res_min(res_min),
`ifdef FILTER_SWEEP_PP_EN
    .res_pp(res_pp),
`endif
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; inputs change 1 ns after the edge, ramp covers -5..+9
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ramp_en) begin
        sample_in = 16'(ramp);
        ramp = (ramp == 9) ? -5 : ramp + 1;
      end
    end
  endtask

  task automatic wait_res(input string tag);
    int k = 0;
    while (res_valid !== 1'b1 && k < 400) begin
      tick(1);
      k++;
    end
    chk(tag, res_valid, 1);
  endtask

  task automatic cfg(input logic [31:0] ps, input logic [31:0] st, input logic [31:0] sp,
                     input logic [31:0] se, input logic [31:0] me);
    period_start = ps; period_step = st; period_stop = sp;
    settle_cycles = se; meas_cycles = me;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_dut_rst", dut_rst, 0);
    chk("rst_gen", gen_period, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_max", res_max, 0);
    #3 rst = 1'b1;
    tick(2);

    // three-point sweep 2,7,12 with ramp samples
    cfg(32'd2, 32'd5, 32'd12, 32'd4, 32'd20);
    ramp_en = 1'b1; sample_valid = 1'b1; res_ready = 1'b1;
    pulse_start();
    chk("s1_busy", busy, 1);
    chk("s1_flush_rst", dut_rst, 0);
    chk("s1_gen", gen_period, 2);
    tick(99);
    chk("s1_flush_last", dut_rst, 0);
    tick(1);
    chk("s1_settle_rst", dut_rst, 1);
    tick(23);
    chk("s1_meas_last", res_valid, 0);
    tick(1);
    chk("s1_p1_valid", res_valid, 1);
    chk("s1_p1_period", res_period, 2);
    chk("s1_p1_max", res_max, 16'd9);
    chk("s1_p1_min", res_min, 16'hFFFB);
`ifdef FILTER_SWEEP_PP_EN
    chk("s1_p1_pp", res_pp, 17'd14);
`endif
    tick(1);
    chk("s1_xfer_valid", res_valid, 0);
    chk("s1_gen2", gen_period, 7);
    chk("s1_reflush", dut_rst, 0);
    wait_res("s1_p2_wait");
    chk("s1_p2_period", res_period, 7);
    chk("s1_p2_min", res_min, 16'hFFFB);
    tick(1);
    wait_res("s1_p3_wait");
    chk("s1_p3_period", res_period, 12);
    chk("s1_p3_max", res_max, 16'd9);
    chk("s1_p3_done_early", done, 0);
    tick(1);
    chk("s1_done", done, 1);
    chk("s1_idle", busy, 0);
    chk("s1_end_valid", res_valid, 0);
    tick(1);
    chk("s1_done_pulse", done, 0);

    // single point, settle 0, stalled REPORT, start while busy ignored
    ramp_en = 1'b0; sample_valid = 1'b0; res_ready = 1'b0;
    cfg(32'd100, 32'd0, 32'd500, 32'd0, 32'd3);
    pulse_start();
    tick(100);
    chk("s2_meas_rst", dut_rst, 1);
    sample_in = 16'd100;   sample_valid = 1'b1;
    tick(1);
    sample_in = 16'hFED4;  sample_valid = 1'b0;
    tick(1);
    chk("s2_meas_busy", res_valid, 0);
    sample_in = 16'hFFF9;  sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    chk("s2_valid", res_valid, 1);
    for (int i = 0; i < 50; i++) begin
      period_start = 32'd999;
      start = (i == 10);
      tick(1);
      if (i % 10 == 9) begin
        chk("s2_stall_valid", res_valid, 1);
        chk("s2_stall_max", res_max, 16'd100);
        chk("s2_stall_min", res_min, 16'hFFF9);
        chk("s2_stall_period", res_period, 100);
        chk("s2_stall_gen", gen_period, 100);
        chk("s2_stall_noflush", dut_rst, 1);
      end
    end
    start = 1'b0;
`ifdef FILTER_SWEEP_PP_EN
    chk("s2_pp", res_pp, 17'd107);
`endif
    res_ready = 1'b1;
    tick(1);
    chk("s2_done", done, 1);
    chk("s2_idle", busy, 0);

    // no valid samples: extremes reported, meas 0 acts as 1
    cfg(32'd50, 32'd0, 32'd0, 32'd2, 32'd0);
    pulse_start();
    tick(102);
    chk("s3_meas", res_valid, 0);
    tick(1);
    chk("s3_valid", res_valid, 1);
    chk("s3_max", res_max, 16'h8000);
    chk("s3_min", res_min, 16'h7FFF);
`ifdef FILTER_SWEEP_PP_EN
    chk("s3_pp", res_pp, 17'h10001);
`endif
    tick(1);
    chk("s3_done", done, 1);

    // abort during SETTLE of second point
    ramp_en = 1'b1; sample_valid = 1'b1;
    cfg(32'd2, 32'd5, 32'd12, 32'd4, 32'd20);
    pulse_start();
    tick(225);
    chk("s4_settle_rst", dut_rst, 1);
    chk("s4_settle_gen", gen_period, 7);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("s4_busy", busy, 0);
    chk("s4_dut_rst", dut_rst, 0);
    chk("s4_valid", res_valid, 0);
    chk("s4_done", done, 0);
    tick(5);
    chk("s4_done_late", done, 0);
    chk("s4_still_idle", busy, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("s4_abort_wins", busy, 0);

    // carry out of the period ends the sweep after one point
    cfg(32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd2);
    pulse_start();
    wait_res("s5_wait");
    chk("s5_period", res_period, 32'hFFFF_FFFE);
    tick(1);
    chk("s5_done", done, 1);
    chk("s5_idle", busy, 0);

    // start above stop still measures one point
    cfg(32'd20, 32'd1, 32'd10, 32'd1, 32'd2);
    pulse_start();
    wait_res("s6_wait");
    chk("s6_period", res_period, 20);
    tick(1);
    chk("s6_done", done, 1);

    // reset in the middle of MEASURE
    cfg(32'd2, 32'd5, 32'd12, 32'd0, 32'd20);
    pulse_start();
    tick(105);
    chk("s7_in_meas", dut_rst, 1);
    rst = 1'b0;
    #1;
    chk("s7_busy", busy, 0);
    chk("s7_dut_rst", dut_rst, 0);
    chk("s7_gen", gen_period, 0);
    chk("s7_valid", res_valid, 0);
    chk("s7_period", res_period, 0);
    chk("s7_max", res_max, 0);
    chk("s7_min", res_min, 0);
    chk("s7_done", done, 0);
    #2 rst = 1'b1;
    tick(20);
    chk("s7_post_busy", busy, 0);
    chk("s7_post_valid", res_valid, 0);
    chk("s7_post_gen", gen_period, 0);
    pulse_start();
    chk("s7_restart", busy, 1);
    chk("s7_restart_gen", gen_period, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/filter_sweep_ctrl.md
FILTER_SWEEP_CTRL -- requirements
Module: filter_sweep_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter PERIOD_WIDTH, default 32, sine_gen period width.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 100, filter-reset hold per sweep point.
REQ-004 SHALL have ports clk  in  1  single clock, all logic on rising edge; rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports start  in  1  sweep start pulse; abort  in  1  sweep abort.
REQ-006 SHALL have ports period_start, period_step, period_stop  in  PERIOD_WIDTH  sweep bounds, sampled at start.
REQ-007 SHALL have ports settle_cycles, meas_cycles  in  32  per-point wait and measure lengths, sampled at start.
REQ-008 SHALL have ports gen_period  out  PERIOD_WIDTH  to sine_gen; dut_rst  out  1  active-low reset to cascade_low_pass_filter.
REQ-009 SHALL have ports sample_in  in  WORD_WIDTH  filter output; sample_valid  in  1  filter output valid.
REQ-010 SHALL have ports res_valid  out  1; res_ready  in  1; res_period  out  PERIOD_WIDTH; res_max, res_min  out  WORD_WIDTH.
REQ-011 SHALL have ports busy  out  1  sweep in progress; done  out  1  one-cycle sweep-complete pulse.

Function
REQ-012 SHALL implement states IDLE, FLUSH, SETTLE, MEASURE, REPORT.
REQ-013 IDLE: start=1 SHALL latch all config inputs, load gen_period=period_start, enter FLUSH; busy=1 in all other states.
REQ-014 FLUSH SHALL drive dut_rst=0 for exactly FLUSH_CYCLES cycles, then enter SETTLE; dut_rst=1 in every other non-IDLE state, 0 in IDLE.
REQ-015 SETTLE SHALL last settle_cycles cycles; settle_cycles=0 enters MEASURE on the next cycle.
REQ-016 MEASURE SHALL last max(meas_cycles,1) cycles; min/max SHALL update only on cycles with sample_valid=1, signed compare.
REQ-017 min/max SHALL initialise to most-positive/most-negative on MEASURE entry; no valid sample leaves them so and they are reported unchanged.
REQ-018 REPORT SHALL hold res_valid=1 with stable res_period/res_max/res_min until res_ready=1 (transfer on res_valid&res_ready).
REQ-019 On transfer, next = gen_period+period_step; if period_step=0, carry out, or next>period_stop: done=1 one cycle, enter IDLE; else load next, enter FLUSH.
REQ-020 start while busy SHALL be ignored; abort in any state SHALL enter IDLE next cycle, res_valid=0, no done pulse.
REQ-021 Simultaneous start and abort in IDLE: abort wins, stay IDLE.
REQ-022 period_start>period_stop SHALL still produce exactly one point.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE, gen_period=0, dut_rst=0, res_valid=0, res_period/res_max/res_min=0, busy=0, done=0.
REQ-024 Reset mid-sweep SHALL discard the sweep; no result or done after release.

Configuration
REQ-025 With FILTER_SWEEP_PP_EN defined, SHALL add output res_pp  WORD_WIDTH+1  = res_max-res_min (signed), registered with res_*; undefined, port and logic absent.

Structure
REQ-026 State enum sweep_state_t and FLUSH_CYCLES default SHALL live in opo_package.
REQ-027 Min/max tracking SHALL be sub-module sweep_minmax (clear, valid, sample -> min, max).

Verification
REQ-028 start=2/step=5/stop=12, settle=4, meas=20, res_ready=1 -> three results, periods 2,7,12, then done pulse, busy=0.
REQ-029 sample_in ramp -5..+9 valid each MEASURE cycle -> res_min=-5, res_max=9 (res_pp=14 with macro).
REQ-030 res_ready held 0 for 50 cycles in REPORT -> res_* stable, gen_period unchanged, no FLUSH.
REQ-031 abort during SETTLE of 2nd point -> IDLE next cycle, dut_rst=0, no done, res_valid=0.
REQ-032 period_start=0xFFFFFFFE, step=5, stop=0xFFFFFFFF -> one result, carry ends sweep, done=1.
REQ-033 rst=0 mid-MEASURE -> all outputs zero immediately; after release only new start resumes activity.
